word_aligner: RTL and testbench
===============================

# word_aligner

Byte-boundary aligner sitting directly downstream of the per-lane input-delay controller. It consumes the 8-bit deserialized positive-leg word once the delay is settled and finds the bit offset that recovers a known training byte. It presents the realigned word to the lane FIFO. Auto mode searches and locks on its own; manual mode applies a software-set offset.

## Interface
Parameters:
- SYNC_WORD, 8'hAC: training byte expected during training; no rotational symmetry.
- MATCH_N, 16: consecutive matches at one offset required to lock (range 1..255).
- MISS_N, 4: consecutive mismatches while locked and training that force a relock (range 1..255).

Ports (one clock; reset is asynchronous and active-high):
- clk160  in  1  lane word clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  8  deserialized word; bit 7 is the earliest received bit.
- data_valid  in  1  word qualifier (delay ready && FIFO ready).
- align_mode  in  1  1 = auto search, 0 = manual offset.
- manual_offset  in  3  offset applied in manual mode.
- train_en  in  1  1 = link is sending SYNC_WORD; enables checking while locked.
- reset_counters  in  1  synchronous clear of err_cnt.
- data_out  out  8  realigned word.
- data_out_valid  out  1  registered copy of data_valid.
- offset  out  3  offset currently applied.
- locked  out  1  auto lock achieved.
- align_timeout  out  1  sticky: a full offset sweep (7→0 wrap) completed without lock.
- err_cnt  out  16  saturating count of training mismatches while locked.

## Operation
- prev_word register loads data_in on each data_valid.
- Window: concat = {prev_word, data_in}; window = concat[7+offset -: 8].
  - Offset 0 gives data_in.
  - Offset k gives {prev_word[k-1:0], data_in[7:k]}.
- Submodule word_align_shift computes window combinationally.
- match = (window == SYNC_WORD), evaluated only when data_valid = 1.
- When data_valid = 0, the FSM, all counters and prev_word are frozen.
- FSM states:
  - IDLE
    - offset tracks manual_offset every cycle; locked = 0.
    - align_mode = 1 → SEARCH with match_cnt = 0. Offset is kept as the search start.
  - SEARCH
    - match → match_cnt + 1. When match_cnt reaches MATCH_N → LOCKED and locked = 1.
    - mismatch → match_cnt = 0 and offset = offset + 1 (mod 8). On a 7→0 wrap, align_timeout is set.
  - LOCKED
    - train_en = 0: no checking; miss_cnt held at 0.
    - train_en = 1, mismatch: miss_cnt + 1, and err_cnt + 1 (saturates at 16'hFFFF).
    - train_en = 1, match: miss_cnt = 0.
    - miss_cnt reaches MISS_N → SEARCH with offset + 1, locked = 0, match_cnt = 0.
- align_mode = 0 in any state → IDLE next edge, regardless of data_valid. Counters are cleared.
- align_timeout clears on entry to LOCKED or IDLE.
- Simultaneous reset_counters with an error increment: the clear wins.

## Timing
- Reset values: data_out = 0, data_out_valid = 0, offset = 0, locked = 0, align_timeout = 0, err_cnt = 0, prev_word = 0, state IDLE, all internal counters 0.
- Latency: data_out and data_out_valid are registered, one clk160 after the data_in/data_valid sample, using the offset in effect at that sample.
- An offset change takes effect on the next valid word. No settle cycle is needed because prev_word is raw data.
- locked rises on the edge that samples the MATCH_N-th consecutive match. It falls on the edge that samples the MISS_N-th miss.
- Reset mid-search returns to IDLE immediately; no partial state survives.

## Configuration
- WORD_ALIGN_ERRCNT_EN defined: err_cnt is implemented as specified.
- WORD_ALIGN_ERRCNT_EN undefined: the err_cnt port remains but is tied to 16'h0, and the counter logic is removed. The relock behaviour via miss_cnt is unchanged.

## Structure
- Shared package word_align_pkg holds:
  - state enum (IDLE, SEARCH, LOCKED);
  - OFFSET_W = 3, ERRCNT_W = 16;
  - default SYNC_WORD.
- One submodule: word_align_shift (pure combinational 16→8 window select).
- Counter widths are derived from MATCH_N/MISS_N with $clog2(N+1).

## Test plan
- Auto lock: repeating 0xAC stream skewed so offset 3 recovers it, data_valid = 1 continuously → three mismatches (offsets 0, 1, 2), then 16 matches. locked = 1 after exactly 19 valid words, offset = 3, data_out = 0xAC thereafter.
- Relock: from the locked state above, change the skew so offset 5 is correct, train_en = 1 → four misses drop locked and err_cnt = 4. The search wraps through 4, 5 and relocks at offset 5.
- No pattern: constant 0x00 in auto mode → offset cycles 0..7, align_timeout = 1 after the 8th mismatch, locked stays 0.
- Manual mode: align_mode = 0, manual_offset = 6, data_in alternating 0xFF/0x00 → data_out = 0x03/0xFC one cycle later. Changing manual_offset takes effect the next cycle.
- Stall and clear: toggle data_valid low for 10 cycles mid-search → match_cnt and offset are frozen. Pulse reset_counters together with a miss → err_cnt = 0. Assert rst mid-LOCKED → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/word_align_pkg.sv
// word_align_pkg: shared types and constants for the lane word aligner.
// Holds the aligner state enum, field widths and the default training byte.
package word_align_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  localparam int OFFSET_W = 3;
  localparam int ERRCNT_W = 16;

  localparam logic [7:0] SYNC_WORD_DEF = 8'hAC;

endpackage

// File: rtl/word_align_shift.sv
// word_align_shift: combinational 16->8 window select for byte alignment.
// Ports: prev_word/data_in (8b, bit 7 earliest), offset (3b) -> window (8b).
module word_align_shift
  import word_align_pkg::*;
(
  input  logic [7:0]          prev_word,
  input  logic [7:0]          data_in,
  input  logic [OFFSET_W-1:0] offset,
  output logic [7:0]          window
);

  logic [15:0] cat;

  assign cat    = {prev_word, data_in};
  assign window = cat[{1'b0, offset} +: 8];

endmodule

// File: rtl/word_aligner.sv
// word_aligner: finds the bit offset recovering SYNC_WORD and realigns words.
// Inputs: clk160, rst (async, high), data_in, data_valid, align_mode,
//   manual_offset, train_en, reset_counters.
// Outputs: data_out, data_out_valid, offset, locked, align_timeout, err_cnt.
// Build option: WORD_ALIGN_ERRCNT_EN enables the err_cnt counter,
//   otherwise err_cnt is tied to zero.
module word_aligner
  import word_align_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int         MATCH_N   = 16,
  parameter int         MISS_N    = 4
) (
  input  logic                clk160,
  input  logic                rst,
  input  logic [7:0]          data_in,
  input  logic                data_valid,
  input  logic                align_mode,
  input  logic [OFFSET_W-1:0] manual_offset,
  input  logic                train_en,
  input  logic                reset_counters,
  output logic [7:0]          data_out,
  output logic                data_out_valid,
  output logic [OFFSET_W-1:0] offset,
  output logic                locked,
  output logic                align_timeout,
  output logic [ERRCNT_W-1:0] err_cnt
);

  localparam int MC_W = $clog2(MATCH_N + 1);
  localparam int XC_W = $clog2(MISS_N + 1);
  localparam logic [MC_W-1:0] MATCH_LAST = MC_W'(MATCH_N);
  localparam logic [XC_W-1:0] MISS_LAST  = XC_W'(MISS_N);

  align_state_e        state_q, state_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic [MC_W-1:0]     match_cnt_q, match_cnt_d, match_inc;
  logic [XC_W-1:0]     miss_cnt_q, miss_cnt_d, miss_inc;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;
  logic [7:0]          prev_q, prev_d;
  logic [7:0]          dout_q, dout_d;
  logic                dval_q, dval_d;
  logic [7:0]          window;
  logic                hit;
  logic                err_inc;

  word_align_shift u_shift (
    .prev_word (prev_q),
    .data_in   (data_in),
    .offset    (offset_q),
    .window    (window)
  );

  assign hit       = (window == SYNC_WORD);
  assign match_inc = match_cnt_q + 1'b1;
  assign miss_inc  = miss_cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    offset_d    = offset_q;
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    locked_d    = locked_q;
    timeout_d   = timeout_q;
    err_inc     = 1'b0;
    prev_d      = data_valid ? data_in : prev_q;
    dout_d      = data_valid ? window : dout_q;
    dval_d      = data_valid;
    if (!align_mode) begin
      // Manual mode overrides everything, valid or not.
      state_d     = IDLE;
      offset_d    = manual_offset;
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      locked_d    = 1'b0;
      timeout_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // Current offset is kept as the search start.
          state_d     = SEARCH;
          match_cnt_d = '0;
        end
        SEARCH: begin
          if (data_valid) begin
            if (hit) begin
              if (match_inc == MATCH_LAST) begin
                state_d     = LOCKED;
                locked_d    = 1'b1;
                timeout_d   = 1'b0;
                match_cnt_d = '0;
              end else begin
                match_cnt_d = match_inc;
              end
            end else begin
              match_cnt_d = '0;
              offset_d    = offset_q + 1'b1;
              if (offset_q == '1) timeout_d = 1'b1;
            end
          end
        end
        LOCKED: begin
          if (data_valid) begin
            if (!train_en || hit) begin
              miss_cnt_d = '0;
            end else begin
              err_inc = 1'b1;
              if (miss_inc == MISS_LAST) begin
                state_d     = SEARCH;
                offset_d    = offset_q + 1'b1;
                locked_d    = 1'b0;
                match_cnt_d = '0;
                miss_cnt_d  = '0;
              end else begin
                miss_cnt_d = miss_inc;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      offset_q    <= '0;
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      prev_q      <= '0;
      dout_q      <= '0;
      dval_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      offset_q    <= offset_d;
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      prev_q      <= prev_d;
      dout_q      <= dout_d;
      dval_q      <= dval_d;
    end
  end

`ifdef WORD_ALIGN_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_q, err_d;

  // A clear in the same cycle as a miss wins over the increment.
  always_comb begin
    err_d = err_q;
    if (reset_counters) err_d = '0;
    else if (err_inc && (err_q != '1)) err_d = err_q + 1'b1;
  end

  always_ff @(posedge clk160 or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_d;
  end

  assign err_cnt = err_q;
`else
  logic unused_err;
  assign unused_err = err_inc ^ reset_counters;
  assign err_cnt    = '0;
`endif

  assign data_out       = dout_q;
  assign data_out_valid = dval_q;
  assign offset         = offset_q;
  assign locked         = locked_q;
  assign align_timeout  = timeout_q;

endmodule

// File: tb/tb_word_aligner.sv
// tb_word_aligner: self-checking bench for word_aligner.
// Directed scenarios plus randomized traffic against a behavioural model.
module tb_word_aligner;

  localparam logic [7:0] SYNC = 8'hAC;
  localparam int MATCH_N = 16;
  localparam int MISS_N  = 4;

  logic        clk160 = 1'b0;
  logic        rst;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        align_mode;
  logic [2:0]  manual_offset;
  logic        train_en;
  logic        reset_counters;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic [2:0]  offset;
  logic        locked;
  logic        align_timeout;
  logic [15:0] err_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state: 0 idle, 1 searching, 2 locked.
  int         m_st, m_off, m_mc, m_xc, m_err;
  bit         m_lock, m_to, m_dval;
  logic [7:0] m_prev, m_dout;

  word_aligner dut (
    .clk160         (clk160),
    .rst            (rst),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .align_mode     (align_mode),
    .manual_offset  (manual_offset),
    .train_en       (train_en),
    .reset_counters (reset_counters),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .offset         (offset),
    .locked         (locked),
    .align_timeout  (align_timeout),
    .err_cnt        (err_cnt)
  );

  always #5 clk160 = ~clk160;

  function automatic logic [15:0] exp_err();
`ifdef WORD_ALIGN_ERRCNT_EN
    return 16'(m_err);
`else
    return 16'h0;
`endif
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] v, int k);
    logic [15:0] t;
    t = {v, v} >> (8 - k);
    return t[7:0];
  endfunction

  task automatic model_reset();
    m_st = 0; m_off = 0; m_mc = 0; m_xc = 0; m_err = 0;
    m_lock = 0; m_to = 0; m_dval = 0; m_prev = 0; m_dout = 0;
  endtask

  // Applies the aligner rules to the inputs seen at one clock edge.
  task automatic model_step();
    logic [15:0] cat;
    logic [7:0]  win;
    bit          hit, inc;
    if (rst) begin
      model_reset();
      return;
    end
    cat = {m_prev, data_in};
    win = 8'(cat >> m_off);
    hit = (win == SYNC);
    inc = 0;
    m_dval = data_valid;
    if (data_valid) begin
      m_dout = win;
      m_prev = data_in;
    end
    if (!align_mode) begin
      m_st = 0; m_off = int'(manual_offset); m_mc = 0; m_xc = 0;
      m_lock = 0; m_to = 0;
    end else if (m_st == 0) begin
      m_st = 1; m_mc = 0;
    end else if (data_valid && m_st == 1) begin
      if (hit) begin
        m_mc++;
        if (m_mc == MATCH_N) begin
          m_st = 2; m_lock = 1; m_to = 0; m_mc = 0;
        end
      end else begin
        m_mc = 0;
        if (m_off == 7) m_to = 1;
        m_off = (m_off + 1) % 8;
      end
    end else if (data_valid && m_st == 2) begin
      if (!train_en || hit) m_xc = 0;
      else begin
        m_xc++;
        inc = 1;
        if (m_xc == MISS_N) begin
          m_st = 1; m_lock = 0; m_off = (m_off + 1) % 8;
          m_xc = 0; m_mc = 0;
        end
      end
    end
    if (reset_counters) m_err = 0;
    else if (inc && m_err != 65535) m_err++;
  endtask

  task automatic tick();
    @(posedge clk160);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; data_in = 0; data_valid = 0; align_mode = 0;
    manual_offset = 0; train_en = 0; reset_counters = 0;
    model_reset();
    tick(); tick();
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL reset_dout got %h want 00", data_out);
    end
    checks++;
    if (data_out_valid !== 1'b0 || locked !== 1'b0 || align_timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got v%b l%b t%b want 000",
               data_out_valid, locked, align_timeout);
    end
    checks++;
    if (offset !== 3'd0 || err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_off_err got %0d/%0d want 0/0", offset, err_cnt);
    end
    rst = 0;
  endtask

  task automatic test_auto_lock();
    reset_counters = 1; tick(); reset_counters = 0;
    align_mode = 1; data_valid = 0; tick();
    data_valid = 1; data_in = 8'h65;
    for (int i = 0; i < 18; i++) tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL auto_early_lock got %b want 0", locked);
    end
    tick();
    checks++;
    if (locked !== 1'b1 || offset !== 3'd3) begin
      errors++; $display("FAIL auto_lock got l%b off%0d want l1 off3", locked, offset);
    end
    tick();
    checks++;
    if (data_out !== 8'hAC || locked !== 1'b1) begin
      errors++; $display("FAIL auto_dout got %h l%b want ac l1", data_out, locked);
    end
  endtask

  task automatic test_relock();
    int n;
    train_en = 1; data_in = 8'h95; n = 0;
    while (locked === 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (n !== 4 || offset !== 3'd4) begin
      errors++; $display("FAIL relock_drop got %0d words off%0d want 4 off4", n, offset);
    end
    checks++;
    if (err_cnt !== exp_err() || exp_err() !== ((m_err == 4) ? exp_err() : 16'hdead)) begin
      errors++; $display("FAIL relock_err got %0d want %0d", err_cnt, exp_err());
    end
    n = 0;
    while (locked !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n !== 17 || offset !== 3'd5) begin
      errors++; $display("FAIL relock_again got %0d words off%0d want 17 off5", n, offset);
    end
    tick();
    checks++;
    if (data_out !== 8'hAC) begin
      errors++; $display("FAIL relock_dout got %h want ac", data_out);
    end
  endtask

  task automatic test_no_pattern();
    train_en = 0;
    align_mode = 0; manual_offset = 0; data_valid = 1; data_in = 0; tick();
    align_mode = 1; data_valid = 0; tick();
    data_valid = 1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (align_timeout !== 1'b0 || offset !== 3'd7) begin
      errors++; $display("FAIL nopat_pre got t%b off%0d want t0 off7", align_timeout, offset);
    end
    tick();
    checks++;
    if (align_timeout !== 1'b1 || offset !== 3'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL nopat_timeout got t%b off%0d l%b want t1 off0 l0",
               align_timeout, offset, locked);
    end
  endtask

  task automatic test_manual();
    logic [7:0] want [4] = '{8'hFC, 8'h03, 8'hFC, 8'h03};
    align_mode = 0; manual_offset = 6; data_valid = 1; data_in = 8'hFF; tick();
    checks++;
    if (align_timeout !== 1'b0 || offset !== 3'd6) begin
      errors++; $display("FAIL manual_idle got t%b off%0d want t0 off6", align_timeout, offset);
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 3) manual_offset = 2;
      data_in = (i % 2 == 0) ? 8'h00 : 8'hFF;
      tick();
      checks++;
      if (data_out !== want[i]) begin
        errors++; $display("FAIL manual_word%0d got %h want %h", i, data_out, want[i]);
      end
    end
    data_in = 8'h00; tick();
    checks++;
    if (data_out !== 8'hC0) begin
      errors++; $display("FAIL manual_change got %h want c0", data_out);
    end
  endtask

  task automatic test_stall_clear();
    align_mode = 0; manual_offset = 0; data_valid = 0; tick();
    align_mode = 1; tick();
    data_valid = 1; data_in = 8'h65;
    for (int i = 0; i < 5; i++) tick();
    data_valid = 0;
    for (int i = 0; i < 10; i++) begin
      data_in = 8'($urandom);
      tick();
      checks++;
      if (offset !== 3'd3 || locked !== 1'b0 || data_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_frozen got off%0d l%b v%b want off3 l0 v0",
                 offset, locked, data_out_valid);
      end
    end
    data_valid = 1; data_in = 8'h65;
    for (int i = 0; i < 13; i++) tick();
    checks++;
    if (locked !== 1'b0) begin
      errors++; $display("FAIL stall_count got l%b want 0", locked);
    end
    tick();
    checks++;
    if (locked !== 1'b1) begin
      errors++; $display("FAIL stall_resume got l%b want 1", locked);
    end
    train_en = 1; data_in = 8'h95; tick();
    checks++;
    if (err_cnt !== exp_err()) begin
      errors++; $display("FAIL clear_pre got %0d want %0d", err_cnt, exp_err());
    end
    reset_counters = 1; tick(); reset_counters = 0;
    checks++;
    if (err_cnt !== 16'h0 || locked !== 1'b1) begin
      errors++; $display("FAIL clear_wins got %0d l%b want 0 l1", err_cnt, locked);
    end
    data_in = 8'h65; tick();
    #2 rst = 1;
    #1;
    model_reset();
    checks++;
    if ({data_out, data_out_valid, offset, locked, align_timeout, err_cnt} !== '0) begin
      errors++;
      $display("FAIL async_rst got d%h v%b o%0d l%b t%b e%0d want all 0",
               data_out, data_out_valid, offset, locked, align_timeout, err_cnt);
    end
    tick();
    rst = 0; align_mode = 0; data_valid = 0; train_en = 0;
    tick();
  endtask

  task automatic test_random();
    int k;
    k = 0;
    for (int c = 0; c < 800; c++) begin
      if (c % 70 == 0) k = $urandom_range(0, 7);
      align_mode     = ($urandom_range(0, 99) != 0);
      manual_offset  = 3'($urandom);
      data_valid     = ($urandom_range(0, 3) != 0);
      data_in        = ($urandom_range(0, 19) == 0) ? 8'($urandom) : rotl8(SYNC, k);
      train_en       = ($urandom_range(0, 9) != 0);
      reset_counters = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (data_out !== m_dout || data_out_valid !== m_dval) begin
        errors++;
        $display("FAIL rand_data c%0d got %h/%b want %h/%b",
                 c, data_out, data_out_valid, m_dout, m_dval);
      end
      checks++;
      if (offset !== 3'(m_off) || locked !== m_lock || align_timeout !== m_to) begin
        errors++;
        $display("FAIL rand_ctl c%0d got o%0d l%b t%b want o%0d l%b t%b",
                 c, offset, locked, align_timeout, m_off, m_lock, m_to);
      end
      checks++;
      if (err_cnt !== exp_err()) begin
        errors++; $display("FAIL rand_err c%0d got %0d want %0d", c, err_cnt, exp_err());
      end
    end
  endtask

  initial begin
    test_reset();
    test_auto_lock();
    test_relock();
    test_no_pattern();
    test_manual();
    test_stall_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
